sobel_frame_sched: RTL and testbench

SOBEL_FRAME_SCHED -- requirements
Module: sobel_frame_sched

---
 rtl/sobel_frame_sched.sv | 205 ++++++++++++++++++++
 tb/tb_sobel_frame_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_sched.sv
// Frame scheduler for a 3x3 Sobel filter: walks output pixels in raster order,
// streams nine zero-padded taps per pixel, collects per-channel results, writes back.
module sobel_frame_sched #(
  parameter int DIM_W  = 8,
  parameter int ADDR_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DIM_W-1:0]  i_width,
  input  logic [DIM_W-1:0]  i_height,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_src_rd,
  output logic [ADDR_W-1:0] o_src_addr,
  input  logic [23:0]       i_src_data,
  output logic              o_rgb_vld,
  output logic [23:0]       o_rgb_data,
  input  logic              i_rgb_busy,
  input  logic              i_result_r_vld,
  input  logic [7:0]        i_result_r_data,
  output logic              o_result_r_busy,
  input  logic              i_result_g_vld,
  input  logic [7:0]        i_result_g_data,
  output logic              o_result_g_busy,
  input  logic              i_result_b_vld,
  input  logic [7:0]        i_result_b_data,
  output logic              o_result_b_busy,
  output logic              o_dst_wr,
  output logic [ADDR_W-1:0] o_dst_addr,
  output logic [23:0]       o_dst_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_TAP, S_CAP, S_SEND, S_COLLECT, S_WR, S_DONE
  } state_t;

  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  state_t             state_q, state_d;
  logic [DIM_W-1:0]   w_q, w_d, h_q, h_d, x_q, x_d, y_q, y_d;
  logic [3:0]         k_q, k_d;
  logic [23:0]        tap_q, tap_d;
  logic [7:0]         r_q, r_d, g_q, g_d, b_q, b_d;
  logic               rv_q, rv_d, gv_q, gv_d, bv_q, bv_d;

  logic [1:0]         kr, kc;
  logic [DIM_W-1:0]   tx, ty;
  logic               col_ok, row_ok;
  logic [ADDR_W-1:0]  tap_addr, pix_addr;
  logic               cap_r, cap_g, cap_b;
  logic               last_col, last_row;

  // Tap index k maps to row offset kr-1 and column offset kc-1.
  always_comb begin
    kr = 2'd1;
    kc = 2'd1;
    case (k_q)
      4'd0: begin kr = 2'd0; kc = 2'd0; end
      4'd1: begin kr = 2'd0; kc = 2'd1; end
      4'd2: begin kr = 2'd0; kc = 2'd2; end
      4'd3: begin kr = 2'd1; kc = 2'd0; end
      4'd4: begin kr = 2'd1; kc = 2'd1; end
      4'd5: begin kr = 2'd1; kc = 2'd2; end
      4'd6: begin kr = 2'd2; kc = 2'd0; end
      4'd7: begin kr = 2'd2; kc = 2'd1; end
      4'd8: begin kr = 2'd2; kc = 2'd2; end
      default: begin kr = 2'd1; kc = 2'd1; end
    endcase
  end

  always_comb begin
    col_ok = 1'b1;
    tx     = x_q;
    case (kc)
      2'd0:    begin col_ok = (x_q != '0); tx = x_q - ONE; end
      2'd2:    begin col_ok = (({1'b0, x_q} + {1'b0, ONE}) < {1'b0, w_q}); tx = x_q + ONE; end
      default: begin col_ok = 1'b1; tx = x_q; end
    endcase
    row_ok = 1'b1;
    ty     = y_q;
    case (kr)
      2'd0:    begin row_ok = (y_q != '0); ty = y_q - ONE; end
      2'd2:    begin row_ok = (({1'b0, y_q} + {1'b0, ONE}) < {1'b0, h_q}); ty = y_q + ONE; end
      default: begin row_ok = 1'b1; ty = y_q; end
    endcase
  end

  assign tap_addr = ADDR_W'(ty) * ADDR_W'(w_q) + ADDR_W'(tx);
  assign pix_addr = ADDR_W'(y_q) * ADDR_W'(w_q) + ADDR_W'(x_q);
  assign last_col = (x_q == w_q - ONE);
  assign last_row = (y_q == h_q - ONE);
  assign cap_r    = i_result_r_vld & ~rv_q;
  assign cap_g    = i_result_g_vld & ~gv_q;
  assign cap_b    = i_result_b_vld & ~bv_q;

  always_comb begin
    state_d = state_q;
    w_d = w_q;   h_d = h_q;   x_d = x_q;   y_d = y_q;   k_d = k_q;
    tap_d = tap_q;
    r_d = r_q;   g_d = g_q;   b_d = b_q;
    rv_d = rv_q; gv_d = gv_q; bv_d = bv_q;
    o_busy          = (state_q != S_IDLE);
    o_done          = 1'b0;
    o_src_rd        = 1'b0;
    o_src_addr      = '0;
    o_rgb_vld       = 1'b0;
    o_rgb_data      = '0;
    o_result_r_busy = 1'b1;
    o_result_g_busy = 1'b1;
    o_result_b_busy = 1'b1;
    o_dst_wr        = 1'b0;
    o_dst_addr      = '0;
    o_dst_data      = '0;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          w_d = i_width;
          h_d = i_height;
          x_d = '0;
          y_d = '0;
          k_d = '0;
          state_d = (i_width == '0 || i_height == '0) ? S_DONE : S_TAP;
        end
      end
      S_TAP: begin
        if (col_ok && row_ok) begin
          o_src_rd   = 1'b1;
          o_src_addr = tap_addr;
          state_d    = S_CAP;
        end else begin
          tap_d   = '0;
          state_d = S_SEND;
        end
      end
      S_CAP: begin
        tap_d   = i_src_data;
        state_d = S_SEND;
      end
      S_SEND: begin
        o_rgb_vld  = 1'b1;
        o_rgb_data = tap_q;
        if (!i_rgb_busy) begin
          if (k_q == 4'd8) begin
            state_d = S_COLLECT;
          end else begin
            k_d     = k_q + 4'd1;
            state_d = S_TAP;
          end
        end
      end
      S_COLLECT: begin
        o_result_r_busy = rv_q;
        o_result_g_busy = gv_q;
        o_result_b_busy = bv_q;
        if (cap_r) r_d = i_result_r_data;
        if (cap_g) g_d = i_result_g_data;
        if (cap_b) b_d = i_result_b_data;
        rv_d = rv_q | cap_r;
        gv_d = gv_q | cap_g;
        bv_d = bv_q | cap_b;
        if (rv_d && gv_d && bv_d) state_d = S_WR;
      end
      S_WR: begin
        o_dst_wr   = 1'b1;
        o_dst_addr = pix_addr;
        o_dst_data = {r_q, g_q, b_q};
        rv_d = 1'b0;
        gv_d = 1'b0;
        bv_d = 1'b0;
        k_d  = '0;
        if (last_col) begin
          x_d     = '0;
          y_d     = y_q + ONE;
          state_d = last_row ? S_DONE : S_TAP;
        end else begin
          x_d     = x_q + ONE;
          state_d = S_TAP;
        end
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      w_q <= '0; h_q <= '0; x_q <= '0; y_q <= '0; k_q <= '0;
      tap_q <= '0;
      r_q <= '0; g_q <= '0; b_q <= '0;
      rv_q <= 1'b0; gv_q <= 1'b0; bv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q <= w_d; h_q <= h_d; x_q <= x_d; y_q <= y_d; k_q <= k_d;
      tap_q <= tap_d;
      r_q <= r_d; g_q <= g_d; b_q <= b_d;
      rv_q <= rv_d; gv_q <= gv_d; bv_q <= bv_d;
    end
  end

endmodule

// File: tb/tb_sobel_frame_sched.sv
// Directed bench for sobel_frame_sched: behavioural source memory, optional
// auto-responding filter, and per-scenario tasks with hand-computed expectations.
module tb_sobel_frame_sched;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1, i_start = 1'b0;
  logic [7:0]  i_width = '0, i_height = '0;
  logic        o_busy, o_done, o_src_rd;
  logic [15:0] o_src_addr;
  logic [23:0] i_src_data;
  logic        o_rgb_vld;
  logic [23:0] o_rgb_data;
  logic        i_rgb_busy = 1'b0;
  logic        i_result_r_vld, i_result_g_vld, i_result_b_vld;
  logic [7:0]  i_result_r_data, i_result_g_data, i_result_b_data;
  logic        o_result_r_busy, o_result_g_busy, o_result_b_busy;
  logic        o_dst_wr;
  logic [15:0] o_dst_addr;
  logic [23:0] o_dst_data;

  logic        auto_res = 1'b1;
  logic        man_r = 1'b0, man_g = 1'b0, man_b = 1'b0;
  logic [7:0]  res_r = '0, res_g = '0, res_b = '0;
  logic [23:0] mem [256];

  logic [15:0] rd_q[$];
  logic [23:0] tap_q[$];
  logic [15:0] wa_q[$];
  logic [23:0] wd_q[$];
  int          done_cnt = 0;
  int          n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  sobel_frame_sched #(.DIM_W(8), .ADDR_W(16)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start),
    .i_width(i_width), .i_height(i_height),
    .o_busy(o_busy), .o_done(o_done),
    .o_src_rd(o_src_rd), .o_src_addr(o_src_addr), .i_src_data(i_src_data),
    .o_rgb_vld(o_rgb_vld), .o_rgb_data(o_rgb_data), .i_rgb_busy(i_rgb_busy),
    .i_result_r_vld(i_result_r_vld), .i_result_r_data(i_result_r_data), .o_result_r_busy(o_result_r_busy),
    .i_result_g_vld(i_result_g_vld), .i_result_g_data(i_result_g_data), .o_result_g_busy(o_result_g_busy),
    .i_result_b_vld(i_result_b_vld), .i_result_b_data(i_result_b_data), .o_result_b_busy(o_result_b_busy),
    .o_dst_wr(o_dst_wr), .o_dst_addr(o_dst_addr), .o_dst_data(o_dst_data)
  );

  assign i_result_r_vld  = auto_res ? ~o_result_r_busy : man_r;
  assign i_result_g_vld  = auto_res ? ~o_result_g_busy : man_g;
  assign i_result_b_vld  = auto_res ? ~o_result_b_busy : man_b;
  assign i_result_r_data = res_r;
  assign i_result_g_data = res_g;
  assign i_result_b_data = res_b;

  always @(posedge clk) begin
    i_src_data <= mem[o_src_addr[7:0]];
    if (!i_rst) begin
      if (o_src_rd) rd_q.push_back(o_src_addr);
      if (o_rgb_vld && !i_rgb_busy) tap_q.push_back(o_rgb_data);
      if (o_dst_wr) begin wa_q.push_back(o_dst_addr); wd_q.push_back(o_dst_data); end
      if (o_done) done_cnt = done_cnt + 1;
    end
  end

  task automatic start_frame(input logic [7:0] w, input logic [7:0] h);
    i_width = w; i_height = h; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int n = 0;
    while (!o_done && n < 3000) begin @(negedge clk); n++; end
    ok = o_done;
  endtask

  task automatic wait_vld(output bit ok);
    int n = 0;
    while (!o_rgb_vld && n < 3000) begin @(negedge clk); n++; end
    ok = o_rgb_vld;
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", o_busy); end
    n_checks++; if ({o_done, o_src_rd, o_rgb_vld, o_dst_wr} !== 4'b0) begin n_fail++; $display("FAIL rst_strobes got %b exp 0000", {o_done, o_src_rd, o_rgb_vld, o_dst_wr}); end
    n_checks++; if ({o_src_addr, o_rgb_data, o_dst_addr, o_dst_data} !== 80'h0) begin n_fail++; $display("FAIL rst_data got %h exp 0", {o_src_addr, o_rgb_data, o_dst_addr, o_dst_data}); end
    n_checks++; if ({o_result_r_busy, o_result_g_busy, o_result_b_busy} !== 3'b111) begin n_fail++; $display("FAIL rst_res_busy got %b exp 111", {o_result_r_busy, o_result_g_busy, o_result_b_busy}); end
    i_rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_1x1;
    logic [23:0] exp_tap [9] = '{24'h0, 24'h0, 24'h0, 24'h0, 24'hA0B0C0, 24'h0, 24'h0, 24'h0, 24'h0};
    int rb = rd_q.size(), tb = tap_q.size(), wb = wa_q.size(), db = done_cnt;
    bit ok;
    mem[0] = 24'hA0B0C0; res_r = 8'h11; res_g = 8'h22; res_b = 8'h33;
    start_frame(8'd1, 8'd1);
    wait_done(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL 1x1_done_timeout got 0 exp 1"); end
    @(negedge clk);
    n_checks++; if ({o_done, o_busy} !== 2'b00) begin n_fail++; $display("FAIL 1x1_done_pulse got %b exp 00", {o_done, o_busy}); end
    n_checks++; if (done_cnt - db !== 1) begin n_fail++; $display("FAIL 1x1_done_cnt got %0d exp 1", done_cnt - db); end
    n_checks++; if (rd_q.size() - rb !== 1 || rd_q[rb] !== 16'h0) begin n_fail++; $display("FAIL 1x1_reads got n=%0d exp n=1 addr 0", rd_q.size() - rb); end
    n_checks++; if (tap_q.size() - tb !== 9) begin n_fail++; $display("FAIL 1x1_tap_cnt got %0d exp 9", tap_q.size() - tb); end
    for (int i = 0; i < 9; i++) begin
      n_checks++; if (tap_q[tb+i] !== exp_tap[i]) begin n_fail++; $display("FAIL 1x1_tap%0d got %h exp %h", i, tap_q[tb+i], exp_tap[i]); end
    end
    n_checks++; if (wa_q.size() - wb !== 1 || wa_q[wb] !== 16'h0 || wd_q[wb] !== 24'h112233) begin n_fail++; $display("FAIL 1x1_write got n=%0d exp n=1 addr 0 data 112233", wa_q.size() - wb); end
  endtask

  task automatic test_3x3;
    logic [23:0] exp_c00 [9];
    logic [23:0] exp_c22 [9];
    int rb = rd_q.size(), tb = tap_q.size(), wb = wa_q.size();
    bit ok;
    for (int i = 0; i < 9; i++) mem[i] = 24'hC00000 | 24'(i);
    exp_c00 = '{24'h0, 24'h0, 24'h0, 24'h0, 24'hC00000, 24'hC00001, 24'h0, 24'hC00003, 24'hC00004};
    exp_c22 = '{24'hC00004, 24'hC00005, 24'h0, 24'hC00007, 24'hC00008, 24'h0, 24'h0, 24'h0, 24'h0};
    res_r = 8'hA1; res_g = 8'hB2; res_b = 8'hC3;
    start_frame(8'd3, 8'd3);
    wait_done(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL 3x3_done_timeout got 0 exp 1"); end
    @(negedge clk);
    n_checks++; if (rd_q.size() - rb !== 49) begin n_fail++; $display("FAIL 3x3_read_cnt got %0d exp 49", rd_q.size() - rb); end
    for (int j = 0; j < 9; j++) begin
      n_checks++; if (rd_q[rb+20+j] !== 16'(j)) begin n_fail++; $display("FAIL 3x3_center_rd%0d got %0d exp %0d", j, rd_q[rb+20+j], j); end
      n_checks++; if (tap_q[tb+36+j] !== (24'hC00000 | 24'(j))) begin n_fail++; $display("FAIL 3x3_center_tap%0d got %h exp %h", j, tap_q[tb+36+j], 24'hC00000 | 24'(j)); end
      n_checks++; if (tap_q[tb+j] !== exp_c00[j]) begin n_fail++; $display("FAIL 3x3_c00_tap%0d got %h exp %h", j, tap_q[tb+j], exp_c00[j]); end
      n_checks++; if (tap_q[tb+72+j] !== exp_c22[j]) begin n_fail++; $display("FAIL 3x3_c22_tap%0d got %h exp %h", j, tap_q[tb+72+j], exp_c22[j]); end
    end
    n_checks++; if (wa_q.size() - wb !== 9) begin n_fail++; $display("FAIL 3x3_write_cnt got %0d exp 9", wa_q.size() - wb); end
    for (int j = 0; j < 9; j++) begin
      n_checks++; if (wa_q[wb+j] !== 16'(j) || wd_q[wb+j] !== 24'hA1B2C3) begin n_fail++; $display("FAIL 3x3_write%0d got %0d/%h exp %0d/a1b2c3", j, wa_q[wb+j], wd_q[wb+j], j); end
    end
  endtask

  task automatic test_backpressure;
    int tb = tap_q.size(), wb = wa_q.size();
    bit ok;
    mem[0] = 24'hA0B0C0; res_r = 8'h01; res_g = 8'h02; res_b = 8'h03;
    i_rgb_busy = 1'b1;
    start_frame(8'd1, 8'd1);
    for (int s = 0; s < 9; s++) begin
      wait_vld(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_vld_timeout tap %0d got 0 exp 1", s); end
      if (s == 4) begin
        for (int c = 0; c < 5; c++) begin
          n_checks++; if ({o_rgb_vld, o_src_rd, o_rgb_data} !== {2'b10, 24'hA0B0C0}) begin n_fail++; $display("FAIL bp_hold%0d got vld=%b rd=%b data=%h exp 1/0/a0b0c0", c, o_rgb_vld, o_src_rd, o_rgb_data); end
          @(negedge clk);
        end
      end
      i_rgb_busy = 1'b0;
      @(negedge clk);
      i_rgb_busy = 1'b1;
    end
    i_rgb_busy = 1'b0;
    wait_done(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_done_timeout got 0 exp 1"); end
    @(negedge clk);
    n_checks++; if (tap_q.size() - tb !== 9 || tap_q[tb+4] !== 24'hA0B0C0 || tap_q[tb+5] !== 24'h0) begin n_fail++; $display("FAIL bp_taps got n=%0d exp n=9 with tap4=a0b0c0", tap_q.size() - tb); end
    n_checks++; if (wa_q.size() - wb !== 1 || wd_q[wb] !== 24'h010203) begin n_fail++; $display("FAIL bp_write got n=%0d exp n=1 data 010203", wa_q.size() - wb); end
  endtask

  task automatic test_result_order;
    int wb = wa_q.size(), n = 0;
    auto_res = 1'b0;
    res_r = 8'h44; res_g = 8'h55; res_b = 8'h66;
    start_frame(8'd1, 8'd1);
    while (o_result_r_busy && n < 3000) begin @(negedge clk); n++; end
    n_checks++; if ({o_result_r_busy, o_result_g_busy, o_result_b_busy} !== 3'b000) begin n_fail++; $display("FAIL ord_collect got %b exp 000", {o_result_r_busy, o_result_g_busy, o_result_b_busy}); end
    man_b = 1'b1; @(negedge clk); man_b = 1'b0;
    n_checks++; if ({o_result_r_busy, o_result_g_busy, o_result_b_busy, o_dst_wr} !== 4'b0010) begin n_fail++; $display("FAIL ord_after_b got %b exp 0010", {o_result_r_busy, o_result_g_busy, o_result_b_busy, o_dst_wr}); end
    man_r = 1'b1; @(negedge clk); man_r = 1'b0;
    n_checks++; if ({o_result_r_busy, o_result_g_busy, o_result_b_busy, o_dst_wr} !== 4'b1010) begin n_fail++; $display("FAIL ord_after_r got %b exp 1010", {o_result_r_busy, o_result_g_busy, o_result_b_busy, o_dst_wr}); end
    man_g = 1'b1; @(negedge clk); man_g = 1'b0;
    n_checks++; if ({o_dst_wr, o_result_g_busy} !== 2'b11 || o_dst_addr !== 16'h0 || o_dst_data !== 24'h445566) begin n_fail++; $display("FAIL ord_write got wr=%b gbusy=%b addr=%h data=%h exp 1/1/0/445566", o_dst_wr, o_result_g_busy, o_dst_addr, o_dst_data); end
    @(negedge clk);
    n_checks++; if ({o_dst_wr, o_done} !== 2'b01) begin n_fail++; $display("FAIL ord_done got %b exp 01", {o_dst_wr, o_done}); end
    @(negedge clk);
    n_checks++; if (wa_q.size() - wb !== 1) begin n_fail++; $display("FAIL ord_write_cnt got %0d exp 1", wa_q.size() - wb); end
    auto_res = 1'b1;
  endtask

  task automatic test_zero_and_ignore;
    int rb = rd_q.size(), wb = wa_q.size(), tb, db;
    bit ok;
    start_frame(8'd0, 8'd5);
    n_checks++; if ({o_done, o_busy} !== 2'b11) begin n_fail++; $display("FAIL zero_done got %b exp 11", {o_done, o_busy}); end
    @(negedge clk);
    n_checks++; if ({o_done, o_busy} !== 2'b00) begin n_fail++; $display("FAIL zero_idle got %b exp 00", {o_done, o_busy}); end
    n_checks++; if (rd_q.size() !== rb || wa_q.size() !== wb) begin n_fail++; $display("FAIL zero_traffic got rd=%0d wr=%0d exp 0/0", rd_q.size() - rb, wa_q.size() - wb); end
    tb = tap_q.size(); db = done_cnt;
    mem[0] = 24'h0F0F0F; res_r = 8'h21; res_g = 8'h43; res_b = 8'h65;
    start_frame(8'd1, 8'd1);
    repeat (3) @(negedge clk);
    start_frame(8'd3, 8'd3);
    wait_done(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ign_done_timeout got 0 exp 1"); end
    repeat (20) @(negedge clk);
    n_checks++; if (o_busy !== 1'b0 || done_cnt - db !== 1) begin n_fail++; $display("FAIL ign_single_frame got busy=%b done=%0d exp 0/1", o_busy, done_cnt - db); end
    n_checks++; if (tap_q.size() - tb !== 9 || wa_q.size() - wb !== 1 || wd_q[wb] !== 24'h214365) begin n_fail++; $display("FAIL ign_frame got taps=%0d writes=%0d exp 9/1", tap_q.size() - tb, wa_q.size() - wb); end
  endtask

  task automatic test_reset_mid;
    int wb = wa_q.size(), n = 0, tb, db;
    bit ok;
    for (int i = 0; i < 9; i++) mem[i] = 24'hD00000 | 24'(i);
    start_frame(8'd3, 8'd3);
    while (wa_q.size() - wb < 2 && n < 3000) begin @(negedge clk); n++; end
    wait_vld(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_vld_timeout got 0 exp 1"); end
    i_rst = 1'b1;
    @(negedge clk);
    n_checks++; if ({o_busy, o_done, o_src_rd, o_rgb_vld, o_dst_wr} !== 5'b0 || o_rgb_data !== 24'h0) begin n_fail++; $display("FAIL mid_rst_out got %b data=%h exp 00000/0", {o_busy, o_done, o_src_rd, o_rgb_vld, o_dst_wr}, o_rgb_data); end
    n_checks++; if ({o_result_r_busy, o_result_g_busy, o_result_b_busy} !== 3'b111) begin n_fail++; $display("FAIL mid_rst_res_busy got %b exp 111", {o_result_r_busy, o_result_g_busy, o_result_b_busy}); end
    i_rst = 1'b0;
    wb = wa_q.size(); db = done_cnt;
    repeat (60) @(negedge clk);
    n_checks++; if (wa_q.size() !== wb || done_cnt !== db || o_busy !== 1'b0) begin n_fail++; $display("FAIL mid_abandon got wr=%0d done=%0d busy=%b exp 0/0/0", wa_q.size() - wb, done_cnt - db, o_busy); end
    tb = tap_q.size();
    mem[0] = 24'h123456; res_r = 8'h77; res_g = 8'h88; res_b = 8'h99;
    start_frame(8'd1, 8'd1);
    wait_done(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_restart_timeout got 0 exp 1"); end
    @(negedge clk);
    n_checks++; if (tap_q.size() - tb !== 9 || tap_q[tb+4] !== 24'h123456) begin n_fail++; $display("FAIL mid_restart_taps got n=%0d exp 9 with tap4=123456", tap_q.size() - tb); end
    n_checks++; if (wa_q.size() - wb !== 1 || wa_q[wb] !== 16'h0 || wd_q[wb] !== 24'h778899) begin n_fail++; $display("FAIL mid_restart_write got n=%0d exp 1 addr 0 data 778899", wa_q.size() - wb); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset;
    test_1x1;
    test_3x3;
    test_backpressure;
    test_result_order;
    test_zero_and_ignore;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
